operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode/register-read pipeline stage that sits directly upstream of the TinyRV1 datapath's execute stage and directly downstream of fetch.
- Extracts rs1/rs2 from the incoming instruction and drives the 2r1w register file read ports.
- Resolves RAW hazards by bypassing from the X/M/W stages, and stalls on load-use hazards.
- Registers pc, inst and both operands into the D/X pipeline register with a valid/ready handshake.

Parameters:
- None. Data widths are fixed at 32 bits and register addresses at 5 bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- in_val  in  1  fetch offers an instruction.
- in_rdy  out  1  stage accepts the instruction this cycle.
- in_pc  in  32  pc of the offered instruction.
- in_inst  in  32  offered instruction word.
- raddr0  out  5  register file read address 0; equals in_inst[19:15] (rs1).
- rdata0  in  32  register file read data 0; combinational, returns 0 for x0.
- raddr1  out  5  register file read address 1; equals in_inst[24:20] (rs2).
- rdata1  in  32  register file read data 1.
- x_val, x_wen, x_is_load  in  1 each  X-stage valid, writes a register, is lw.
- x_waddr  in  5  X-stage destination register.
- x_wdata  in  32  X-stage result.
- m_val, m_wen  in  1 each  M-stage valid and write enable.
- m_waddr  in  5  M-stage destination register.
- m_wdata  in  32  M-stage result.
- w_val, w_wen  in  1 each  W-stage valid and write enable; drives the regfile write port.
- w_waddr  in  5  W-stage destination register.
- w_wdata  in  32  W-stage result.
- squash  in  1  taken branch/jump resolved in X; kill younger instructions.
- out_val  out  1  D/X register holds a valid instruction.
- out_rdy  in  1  execute consumes the D/X register.
- out_pc  out  32  registered pc.
- out_inst  out  32  registered instruction.
- out_op0  out  32  registered rs1 operand.
- out_op1  out  32  registered rs2 operand.
- stall_count  out  32  number of load-use stall cycles since reset; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (rst=0, asynchronous): out_val=0; out_pc, out_inst, out_op0, out_op1 and stall_count all 0.
- Source usage is decoded from opcode in_inst[6:0]:
  - use0 = (opcode != 7'b1101111), i.e. every instruction except jal.
  - use1 = opcode is one of 0110011 (R-type), 0100011 (sw), 1100011 (bne).
- Bypass for operand k (k = 0 or 1, rs = raddrk), priority X > M > W > rdatak:
  - Stage S matches when S_val && S_wen && S_waddr == rs && rs != 0.
  - rs == 0 always yields 0 and is never bypassed.
  - W bypass is mandatory: the register file returns old data when waddr == raddr.
  - X bypass is taken only if !x_is_load.
- load_use = in_val && x_val && x_wen && x_is_load && x_waddr != 0 && ((use0 && x_waddr == raddr0) || (use1 && x_waddr == raddr1)).
- Handshake:
  - in_rdy = squash || (!load_use && (!out_val || out_rdy)).
  - Accept when in_val && in_rdy.
  - An unused operand is still captured from the bypass/regfile value; its content is don't-care, but it must be deterministic.
- D/X register update priority, per cycle:
  1. squash: out_val <= 0 next cycle. Any instruction accepted this cycle is discarded. Data fields hold.
  2. accept: out_val <= 1; pc, inst and operands load. Latency is 1 cycle from accept to out_val.
  3. out_val && out_rdy with no accept: out_val <= 0.
  4. Otherwise hold all fields unchanged (stable while out_val && !out_rdy).
- stall_count increments on each cycle with load_use && !squash && (!out_val || out_rdy), then saturates.
- Operand values are captured only at the accept edge. Writes occurring while the register is held do not alter out_op0/out_op1.
- Reset asserted mid-stall clears state immediately; after release the next accept behaves as after a fresh reset.
- rst is the only asynchronous element; all other logic is synchronous to clk.

Test Plan:
- Reset then no bypass:
  - Stimulus: rst low→high; regfile x1=5, x2=7; offer add x3,x1,x2 (0x002081B3), pc=0x200, out_rdy=1.
  - Required: next cycle out_val=1, out_op0=5, out_op1=7, out_pc=0x200.
- Bypass priority:
  - Stimulus: x1 written in X (0x11), M (0x22) and W (0x33) simultaneously, none a load.
  - Required: out_op0=0x11. Drop X → 0x22. Drop X and M → 0x33 (regfile rdata0 still old, 5).
- x0 protection:
  - Stimulus: add x3,x0,x2 with x_waddr=0, x_wen=1, x_wdata=0xDEAD.
  - Required: out_op0=0.
- Load-use stall:
  - Stimulus: X holds lw x1 (x_is_load=1) and D offers add using x1.
  - Required: in_rdy=0, stall_count 0→1. Next cycle the load moves to M with m_wdata=0x44: accepted, out_op0=0x44.
  - Stimulus: jal rd=x1 (x1 unused) under the same X load.
  - Required: no stall.
- Squash:
  - Stimulus: out_val=1, then squash=1 with in_val=1.
  - Required: in_rdy=1, next cycle out_val=0, offered instruction not registered.
  - Stimulus: squash during load_use.
  - Required: stall_count unchanged.
- Backpressure and mid-stall reset:
  - Stimulus: out_rdy=0 with out_val=1 for 3 cycles while W writes the source register.
  - Required: all outputs hold and in_rdy=0.
  - Stimulus: assert rst mid-hold.
  - Required: out_val=0 and stall_count=0 immediately, without a clock edge.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Decode/register-read stage: reads rs1/rs2, bypasses from X/M/W, stalls on
// load-use hazards and registers pc/inst/operands into the D/X register.

module operand_bypass (
    input  logic [4:0]  rs,
    input  logic [31:0] rdata,
    input  logic        x_val,
    input  logic        x_wen,
    input  logic        x_is_load,
    input  logic [4:0]  x_waddr,
    input  logic [31:0] x_wdata,
    input  logic        m_val,
    input  logic        m_wen,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    input  logic        w_val,
    input  logic        w_wen,
    input  logic [4:0]  w_waddr,
    input  logic [31:0] w_wdata,
    output logic [31:0] value
);
    logic x_hit, m_hit, w_hit;

    // A load in X has no data yet, so it never forwards; older stages still may.
    assign x_hit = x_val && x_wen && !x_is_load && (x_waddr == rs);
    assign m_hit = m_val && m_wen && (m_waddr == rs);
    assign w_hit = w_val && w_wen && (w_waddr == rs);

    always_comb begin
        value = rdata;
        if (rs == 5'd0)  value = 32'd0;
        else if (x_hit)  value = x_wdata;
        else if (m_hit)  value = m_wdata;
        else if (w_hit)  value = w_wdata;
    end
endmodule

module operand_fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic [4:0]  raddr0,
    input  logic [31:0] rdata0,
    output logic [4:0]  raddr1,
    input  logic [31:0] rdata1,
    input  logic        x_val,
    input  logic        x_wen,
    input  logic        x_is_load,
    input  logic [4:0]  x_waddr,
    input  logic [31:0] x_wdata,
    input  logic        m_val,
    input  logic        m_wen,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    input  logic        w_val,
    input  logic        w_wen,
    input  logic [4:0]  w_waddr,
    input  logic [31:0] w_wdata,
    input  logic        squash,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_op0,
    output logic [31:0] out_op1,
    output logic [31:0] stall_count
);
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BNE = 7'b1100011;

    logic [6:0]       opcode;
    logic             use0, use1;
    logic             load_use, drain_ok, accept, stall_inc;
    logic [1:0][4:0]  rs;
    logic [1:0][31:0] rdata;
    logic [1:0][31:0] byp;

    assign opcode = in_inst[6:0];
    assign raddr0 = in_inst[19:15];
    assign raddr1 = in_inst[24:20];
    assign use0   = (opcode != OP_JAL);
    assign use1   = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BNE);

    assign rs    = {raddr1, raddr0};
    assign rdata = {rdata1, rdata0};

    for (genvar k = 0; k < 2; k++) begin : g_byp
        operand_bypass u_byp (
            .rs(rs[k]), .rdata(rdata[k]),
            .x_val(x_val), .x_wen(x_wen), .x_is_load(x_is_load),
            .x_waddr(x_waddr), .x_wdata(x_wdata),
            .m_val(m_val), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
            .w_val(w_val), .w_wen(w_wen), .w_waddr(w_waddr), .w_wdata(w_wdata),
            .value(byp[k])
        );
    end

    assign load_use = in_val && x_val && x_wen && x_is_load && (x_waddr != 5'd0) &&
                      ((use0 && (x_waddr == raddr0)) || (use1 && (x_waddr == raddr1)));
    assign drain_ok  = !out_val || out_rdy;
    // Squash always takes the offer so fetch can be redirected; it is then dropped.
    assign in_rdy    = squash || (!load_use && drain_ok);
    assign accept    = in_val && in_rdy && !squash;
    assign stall_inc = load_use && !squash && drain_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_val     <= 1'b0;
            out_pc      <= 32'd0;
            out_inst    <= 32'd0;
            out_op0     <= 32'd0;
            out_op1     <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (squash) begin
                out_val <= 1'b0;
            end else if (accept) begin
                out_val  <= 1'b1;
                out_pc   <= in_pc;
                out_inst <= in_inst;
                out_op0  <= byp[0];
                out_op1  <= byp[1];
            end else if (out_val && out_rdy) begin
                out_val <= 1'b0;
            end
            if (stall_inc && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios with literal expectations,
// then random traffic compared every cycle against a rule-level model.

module tb_operand_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_val, in_rdy;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  raddr0, raddr1;
    logic [31:0] rdata0, rdata1;
    logic        x_val, x_wen, x_is_load;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        m_val, m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        w_val, w_wen;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic        squash, out_val, out_rdy;
    logic [31:0] out_pc, out_inst, out_op0, out_op1, stall_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];
    logic        e_val;
    logic [31:0] e_pc, e_inst, e_op0, e_op1, e_stall;

    localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;
    localparam logic [31:0] ADD_X3_X0_X2 = 32'h0020_01B3;
    localparam logic [31:0] JAL_X1_RS1   = 32'h0000_80EF;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
        .in_pc(in_pc), .in_inst(in_inst),
        .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
        .x_val(x_val), .x_wen(x_wen), .x_is_load(x_is_load),
        .x_waddr(x_waddr), .x_wdata(x_wdata),
        .m_val(m_val), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .w_val(w_val), .w_wen(w_wen), .w_waddr(w_waddr), .w_wdata(w_wdata),
        .squash(squash), .out_val(out_val), .out_rdy(out_rdy),
        .out_pc(out_pc), .out_inst(out_inst), .out_op0(out_op0), .out_op1(out_op1),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Register file: combinational read with old data on same-cycle write.
    assign rdata0 = (raddr0 == 5'd0) ? 32'd0 : regs[raddr0];
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (x_val && x_wen && !x_is_load && x_waddr == r) return x_wdata;
        if (m_val && m_wen && m_waddr == r) return m_wdata;
        if (w_val && w_wen && w_waddr == r) return w_wdata;
        return regs[r];
    endfunction

    function automatic logic m_lu();
        logic [6:0] op;
        logic u0, u1;
        op = in_inst[6:0];
        u0 = op != 7'b1101111;
        u1 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return in_val && x_val && x_wen && x_is_load && x_waddr != 5'd0 &&
               ((u0 && x_waddr == in_inst[19:15]) || (u1 && x_waddr == in_inst[24:20]));
    endfunction

    function automatic logic m_rdy();
        return squash || (!m_lu() && (!e_val || out_rdy));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_val <= 1'b0; e_pc <= '0; e_inst <= '0; e_op0 <= '0; e_op1 <= '0; e_stall <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (squash) e_val <= 1'b0;
            else if (in_val && m_rdy()) begin
                e_val <= 1'b1; e_pc <= in_pc; e_inst <= in_inst;
                e_op0 <= m_fwd(in_inst[19:15]); e_op1 <= m_fwd(in_inst[24:20]);
            end else if (out_rdy) e_val <= 1'b0;
            if (m_lu() && !squash && (!e_val || out_rdy) && e_stall != 32'hFFFF_FFFF)
                e_stall <= e_stall + 32'd1;
            if (w_val && w_wen && w_waddr != 5'd0) regs[w_waddr] <= w_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_out_val", {31'd0, out_val}, {31'd0, e_val});
            chk("m_out_pc", out_pc, e_pc);
            chk("m_out_inst", out_inst, e_inst);
            chk("m_out_op0", out_op0, e_op0);
            chk("m_out_op1", out_op1, e_op1);
            chk("m_stall", stall_count, e_stall);
            chk("m_in_rdy", {31'd0, in_rdy}, {31'd0, m_rdy()});
            chk("m_raddr", {22'd0, raddr1, raddr0}, {22'd0, in_inst[24:20], in_inst[19:15]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_val = 0; in_pc = 0; in_inst = 0; squash = 0; out_rdy = 1;
        x_val = 0; x_wen = 0; x_is_load = 0; x_waddr = 0; x_wdata = 0;
        m_val = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
        w_val = 0; w_wen = 0; w_waddr = 0; w_wdata = 0;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        step(); step();
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        rst = 1;

        // preload x1=5, x2=7 through the write port
        w_val = 1; w_wen = 1; w_waddr = 1; w_wdata = 32'h5; step();
        w_waddr = 2; w_wdata = 32'h7; step();
        w_val = 0; w_wen = 0;

        in_val = 1; in_pc = 32'h200; in_inst = ADD_X3_X1_X2; #1;
        chk("nobyp_in_rdy", {31'd0, in_rdy}, 32'd1);
        step();
        chk("nobyp_out_val", {31'd0, out_val}, 32'd1);
        chk("nobyp_op0", out_op0, 32'h5);
        chk("nobyp_op1", out_op1, 32'h7);
        chk("nobyp_pc", out_pc, 32'h200);

        // W only (regfile still returns 5), then M+W, then X+M+W
        in_pc = 32'h204;
        w_val = 1; w_wen = 1; w_waddr = 1; w_wdata = 32'h33; step();
        chk("byp_w", out_op0, 32'h33);
        m_val = 1; m_wen = 1; m_waddr = 1; m_wdata = 32'h22; step();
        chk("byp_m", out_op0, 32'h22);
        x_val = 1; x_wen = 1; x_waddr = 1; x_wdata = 32'h11; step();
        chk("byp_x", out_op0, 32'h11);
        chk("byp_x_op1", out_op1, 32'h7);

        m_val = 0; m_wen = 0; w_val = 0; w_wen = 0;
        x_waddr = 0; x_wdata = 32'hDEAD; in_inst = ADD_X3_X0_X2; step();
        chk("x0_op0", out_op0, 32'd0);
        chk("x0_op1", out_op1, 32'h7);

        x_waddr = 1; x_is_load = 1; in_inst = ADD_X3_X1_X2; in_pc = 32'h208; #1;
        chk("lu_in_rdy", {31'd0, in_rdy}, 32'd0);
        step();
        chk("lu_stall", stall_count, 32'd1);
        chk("lu_drained", {31'd0, out_val}, 32'd0);
        x_val = 0; x_wen = 0; x_is_load = 0;
        m_val = 1; m_wen = 1; m_waddr = 1; m_wdata = 32'h44; #1;
        chk("lu_release_rdy", {31'd0, in_rdy}, 32'd1);
        step();
        chk("lu_op0", out_op0, 32'h44);
        chk("lu_out_val", {31'd0, out_val}, 32'd1);

        m_val = 0; m_wen = 0;
        x_val = 1; x_wen = 1; x_is_load = 1; x_waddr = 1;
        in_inst = JAL_X1_RS1; in_pc = 32'h210; #1;
        chk("jal_rdy", {31'd0, in_rdy}, 32'd1);
        step();
        chk("jal_stall", stall_count, 32'd1);
        chk("jal_inst", out_inst, JAL_X1_RS1);

        x_val = 0; x_wen = 0; x_is_load = 0;
        squash = 1; in_inst = ADD_X3_X1_X2; in_pc = 32'h300; #1;
        chk("sq_rdy", {31'd0, in_rdy}, 32'd1);
        step();
        chk("sq_out_val", {31'd0, out_val}, 32'd0);
        chk("sq_pc_held", out_pc, 32'h210);
        x_val = 1; x_wen = 1; x_is_load = 1; x_waddr = 1; #1;
        chk("sq_lu_rdy", {31'd0, in_rdy}, 32'd1);
        step();
        chk("sq_lu_stall", stall_count, 32'd1);
        chk("sq_lu_val", {31'd0, out_val}, 32'd0);

        squash = 0; x_val = 0; x_wen = 0; x_is_load = 0; in_pc = 32'h400; step();
        chk("bp_val", {31'd0, out_val}, 32'd1);
        chk("bp_op0", out_op0, 32'h33);
        out_rdy = 0; in_pc = 32'h500; in_inst = 32'h0000_0013;
        w_val = 1; w_wen = 1; w_waddr = 1; w_wdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
            step();
            chk("bp_hold_val", {31'd0, out_val}, 32'd1);
            chk("bp_hold_pc", out_pc, 32'h400);
            chk("bp_hold_op0", out_op0, 32'h33);
        end
        rst = 0; #1;
        chk("mid_rst_val", {31'd0, out_val}, 32'd0);
        chk("mid_rst_stall", stall_count, 32'd0);
        idle_inputs();
        step();
        rst = 1;

        for (int c = 0; c < 3000; c++) begin
            logic [6:0] ops [6];
            ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0000011, 7'b0010011};
            in_val  = ($urandom_range(0, 3) != 0);
            in_pc   = $urandom;
            in_inst = $urandom;
            in_inst[6:0]   = ops[$urandom_range(0, 5)];
            in_inst[19:15] = 5'($urandom_range(0, 3));
            in_inst[24:20] = 5'($urandom_range(0, 3));
            squash  = ($urandom_range(0, 15) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            x_val = $urandom; x_wen = $urandom; x_is_load = $urandom;
            x_waddr = 5'($urandom_range(0, 3)); x_wdata = $urandom;
            m_val = $urandom; m_wen = $urandom;
            m_waddr = 5'($urandom_range(0, 3)); m_wdata = $urandom;
            w_val = $urandom; w_wen = $urandom;
            w_waddr = 5'($urandom_range(0, 3)); w_wdata = $urandom;
            step();
        end

        idle_inputs();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
